// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC selection with static branch prediction and mispredict recovery.
// Optional statistics counters are compiled in with `define BRANCH_STATS_EN.
module pc_redirect_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  Branch_d,
  input  logic                  predict_taken,
  input  logic [DATA_WIDTH-1:0] target_d,
  input  logic                  Branch_e,
  input  logic                  EQ,
  input  logic [DATA_WIDTH-1:0] correct_PC,
  output logic [DATA_WIDTH-1:0] PC_f,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  mispredict,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t state;
  logic pred_e, run, br_e, redirect;
  logic [DATA_WIDTH-1:0] pc_next;
  always_comb begin
    run        = state == RUN;
    br_e       = run & Branch_e;
    redirect   = run & Branch_d & predict_taken;
    mispredict = br_e & (EQ != pred_e);
    flush_e    = mispredict;
    flush_d    = mispredict | (redirect & ~stall);
    pc_next    = mispredict ? correct_PC :
                 stall      ? PC_f :
                 redirect   ? target_d : PC_f + DATA_WIDTH'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      PC_f   <= RESET_PC;
      pred_e <= 1'b0;
    end else begin
      state  <= mispredict ? RECOVER : RUN;
      PC_f   <= pc_next;
      pred_e <= (mispredict | stall | ~run) ? 1'b0 : Branch_d & predict_taken;
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (br_e && branch_count != '1) branch_count <= branch_count + 32'd1;
      if (mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed self-checking bench for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
  logic clk, rst, stall, Branch_d, predict_taken, Branch_e, EQ;
  logic [31:0] target_d, correct_PC, PC_f, branch_count, mispredict_count;
  logic flush_d, flush_e, mispredict;
  int vectors = 0;
  int errs = 0;
  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .Branch_d(Branch_d),
    .predict_taken(predict_taken), .target_d(target_d), .Branch_e(Branch_e),
    .EQ(EQ), .correct_PC(correct_PC), .PC_f(PC_f), .flush_d(flush_d),
    .flush_e(flush_e), .mispredict(mispredict), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic r, s, bd, pt, input logic [31:0] td, input logic be, eq, input logic [31:0] cp);
    @(negedge clk);
    rst = r; stall = s; Branch_d = bd; predict_taken = pt; target_d = td;
    Branch_e = be; EQ = eq; correct_PC = cp;
    #1;
  endtask
  task automatic flags(input string tag, input logic fd, fe, mp);
    chk({tag, ".flush_d"}, {31'd0, flush_d}, {31'd0, fd});
    chk({tag, ".flush_e"}, {31'd0, flush_e}, {31'd0, fe});
    chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mp});
  endtask
  task automatic stats(input string tag, input logic [31:0] bc, mc);
`ifdef BRANCH_STATS_EN
    chk({tag, ".branch_count"}, branch_count, bc);
    chk({tag, ".mispredict_count"}, mispredict_count, mc);
`else
    chk({tag, ".branch_count"}, branch_count, 32'd0);
    chk({tag, ".mispredict_count"}, mispredict_count, 32'd0);
`endif
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.pc", PC_f, 32'h0);
    flags("reset", 0, 0, 0);
    stats("reset", 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq.pc1", PC_f, 32'h4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq.pc2", PC_f, 32'h8);
    drive(0, 0, 1, 1, 32'h40, 0, 0, 0);
    chk("seq.pc3", PC_f, 32'hC);
    flags("redirect", 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    chk("redirect.pc", PC_f, 32'h40);
    flags("correct_pred", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h100);
    chk("seq.pc44", PC_f, 32'h44);
    flags("mispred", 1, 1, 1);
    drive(0, 0, 1, 1, 32'h40, 1, 1, 32'h500);
    chk("mispred.pc", PC_f, 32'h100);
    flags("recover", 0, 0, 0);
    drive(0, 1, 1, 1, 32'h40, 1, 1, 32'h200);
    chk("recover.pc", PC_f, 32'h104);
    flags("conflict", 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("conflict.pc", PC_f, 32'h200);
    drive(0, 0, 1, 1, 32'h40, 0, 0, 0);
    chk("rst_recover.pc", PC_f, 32'h0);
    flags("rst_recover", 1, 0, 0);
    stats("rst_recover", 0, 0);
    drive(0, 0, 1, 0, 32'h80, 1, 1, 0);
    chk("run_after_rst.pc", PC_f, 32'h40);
    flags("stats1", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("stats2.pc", PC_f, 32'h44);
    flags("stats2", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    chk("stats3.pc", PC_f, 32'h48);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h300);
    chk("stall.pc", PC_f, 32'h48);
    flags("stats4", 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stats4.pc", PC_f, 32'h300);
    stats("stats", 4, 1);
    drive(0, 1, 1, 1, 32'h40, 0, 0, 0);
    chk("seq.pc304", PC_f, 32'h304);
    flags("stall_redirect", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("stall_redirect.pc", PC_f, 32'h304);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap.top", PC_f, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap.pc", PC_f, 32'h0);
    stats("final", 5, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of all address ports.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch PC after reset.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hazard stall: freeze fetch PC and IF/ID.
REQ-006 Branch_d  input  1  decode-stage instruction is a conditional branch.
REQ-007 predict_taken  input  1  static prediction for the decode-stage branch (1 = taken).
REQ-008 target_d  input  DATA_WIDTH  predicted target of the decode-stage branch (PC_d + ImmExt_d).
REQ-009 Branch_e  input  1  execute-stage instruction is a conditional branch.
REQ-010 EQ  input  1  actual branch outcome in execute (1 = taken).
REQ-011 correct_PC  input  DATA_WIDTH  resolved next PC for the execute-stage branch.
REQ-012 PC_f  output  DATA_WIDTH  registered fetch PC.
REQ-013 flush_d  output  1  clear IF/ID register this cycle.
REQ-014 flush_e  output  1  clear ID/EX register this cycle.
REQ-015 mispredict  output  1  execute-stage branch mispredicted this cycle.
REQ-016 branch_count, mispredict_count  output  32 each  statistics (see Configuration).

Function
REQ-017 Block SHALL hold a registered bit pred_e: the prediction travelling with the instruction in execute.
REQ-018 mispredict SHALL be combinational: state==RUN & Branch_e & (EQ != pred_e).
REQ-019 FSM SHALL have states RUN and RECOVER; RUN->RECOVER on mispredict; RECOVER->RUN unconditionally after one cycle.
REQ-020 In RECOVER, Branch_d and Branch_e SHALL be treated as 0 (pipeline holds bubbles).
REQ-021 Next-PC priority SHALL be: rst -> RESET_PC; mispredict -> correct_PC; stall -> hold; decode redirect (RUN & Branch_d & predict_taken) -> target_d; else PC_f + 4.
REQ-022 PC_f + 4 SHALL wrap modulo 2^DATA_WIDTH.
REQ-023 flush_d SHALL be 1 on mispredict, or on decode redirect when stall=0.
REQ-024 flush_e SHALL be 1 only on mispredict.
REQ-025 Mispredict SHALL override a simultaneous stall and decode redirect.
REQ-026 pred_e next value: 0 on mispredict, stall, or RECOVER; else Branch_d & predict_taken.
REQ-027 Redirect latency SHALL be one cycle: new PC_f visible the cycle after the deciding condition.

Reset
REQ-028 On rst, SHALL set PC_f=RESET_PC, pred_e=0, state=RUN, counters=0.
REQ-029 rst SHALL override every other input, including mid-RECOVER and coincident mispredict.
REQ-030 flush_d, flush_e, mispredict SHALL read 0 in the first cycle after reset with Branch_e=0.

Configuration
REQ-031 Macro BRANCH_STATS_EN SHALL compile in statistics counters.
REQ-032 With BRANCH_STATS_EN: branch_count increments per cycle with RUN & Branch_e; mispredict_count per mispredict; both saturate at 32'hFFFF_FFFF.
REQ-033 Without BRANCH_STATS_EN: no counter flops; both outputs tied to 0; all other behaviour identical.

Verification
REQ-034 Reset: rst=1 one cycle, RESET_PC=0 -> PC_f=0x0, flush_d=flush_e=mispredict=0, counters=0.
REQ-035 Sequential: no branches, 3 cycles -> PC_f 0x0, 0x4, 0x8, 0xC.
REQ-036 Correct taken prediction: Branch_d=1, predict_taken=1, target_d=0x40 -> flush_d=1, next PC_f=0x40; next cycle Branch_e=1, EQ=1 -> mispredict=0, flush_e=0.
REQ-037 Mispredict: pred_e=0, Branch_e=1, EQ=1, correct_PC=0x100 -> mispredict=flush_d=flush_e=1, next PC_f=0x100, one RECOVER cycle with Branch_d=1 ignored.
REQ-038 Conflict: stall=1, mispredict, and decode redirect to 0x40 same cycle, correct_PC=0x200 -> next PC_f=0x200; rst asserted in RECOVER -> PC_f=RESET_PC, state RUN.
REQ-039 Stats (BRANCH_STATS_EN): 4 resolved branches, 1 mispredicted -> branch_count=4, mispredict_count=1; without macro both 0.
